alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 22 ++
 rtl/alu_arbiter_alu8_core.sv | 28 ++
 rtl/alu_arbiter.sv | 82 ++++++++
 tb/tb_alu_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: opcodes, FSM states and ripple-carry helper shared by the arbiter and its ALU
package alu_arbiter_pkg;
  localparam logic [2:0] OP_ADDC  = 3'b000;
  localparam logic [2:0] OP_ADDZ  = 3'b001;
  localparam logic [2:0] OP_ORXOR = 3'b010;
  localparam logic [2:0] OP_ANY   = 3'b011;
  localparam logic [2:0] OP_ALL   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_HOLD  = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
  function automatic logic [4:0] ripple_add4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] c;
    logic [3:0] s;
    c[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    return {c[4], s};
  endfunction
endpackage

// File: rtl/alu_arbiter_alu8_core.sv
// alu8_core: combinational 8-bit-result ALU
//   op  : opcode, a : operand A, b : operand B (acc[3:0]), acc : accumulator (hold)
//   f   : result
module alu8_core
  import alu_arbiter_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [7:0] acc,
  output logic [7:0] f
);
  logic [4:0] w_sum;
  logic [7:0] w_a8;
  logic [7:0] w_b8;
  assign w_sum = ripple_add4(a, b);
  assign w_a8  = {4'b0, a};
  assign w_b8  = {4'b0, b};
  // a shift by 8..15 of an 8-bit value naturally yields zero
  assign f = (op == OP_ADDC)  ? {3'b0, w_sum} :
             (op == OP_ADDZ)  ? w_a8 + w_b8 :
             (op == OP_ORXOR) ? {a | b, a ^ b} :
             (op == OP_ANY)   ? (((a | b) != 4'h0) ? 8'h18 : 8'h00) :
             (op == OP_ALL)   ? (((a & b) == 4'hF) ? 8'hE7 : 8'h00) :
             (op == OP_SHL)   ? w_a8 << b :
             (op == OP_MUL)   ? w_a8 * w_b8 :
                                acc;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end to a shared accumulator ALU
//   clk, resetn (sync, active-low)
//   req0/op0/a0, req1/op1/a1 : requests with opcode and operand A
//   gnt0/gnt1 : one-hot grant over EXEC..RESP; done0/done1 : one-cycle completion
//   result : accumulator when done is high; acc : live accumulator; busy : EXEC or RESP
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       req0,
  input  logic [2:0] op0,
  input  logic [3:0] a0,
  input  logic       req1,
  input  logic [2:0] op1,
  input  logic [3:0] a1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic [7:0] acc,
  output logic       busy
);
  state_e     r_state;
  state_e     w_next;
  logic [2:0] r_op_q;
  logic [3:0] r_a_q;
  logic [7:0] r_acc;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_last;
  logic       w_win1;
  logic       w_start;
  logic [7:0] w_f;
  alu8_core u_alu (
    .op  (r_op_q),
    .a   (r_a_q),
    .b   (r_acc[3:0]),
    .acc (r_acc),
    .f   (w_f)
  );
  always_ff @(posedge clk)
    r_state <= !resetn ? S_IDLE : w_next;
  // r_last names the side granted most recently; a tie goes to the other side
  always_comb begin
    w_start = (r_state == S_IDLE) && (req0 || req1);
    w_win1  = req1 && (!req0 || !r_last);
    w_next  = (r_state == S_IDLE) ? (w_start ? S_EXEC : S_IDLE) :
              (r_state == S_EXEC) ? S_RESP : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_op_q <= 3'b0;
      r_a_q  <= 4'b0;
      r_acc  <= 8'h00;
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_last <= 1'b1;
    end else begin
      if (w_start) begin
        r_op_q <= w_win1 ? op1 : op0;
        r_a_q  <= w_win1 ? a1 : a0;
        r_gnt0 <= !w_win1;
        r_gnt1 <= w_win1;
        r_last <= w_win1;
      end
      if (r_state == S_EXEC) r_acc <= w_f;
      if (r_state == S_RESP) begin
        r_gnt0 <= 1'b0;
        r_gnt1 <= 1'b0;
      end
    end
  end
  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign done0  = (r_state == S_RESP) && r_gnt0;
  assign done1  = (r_state == S_RESP) && r_gnt1;
  assign result = r_acc;
  assign acc    = r_acc;
  assign busy   = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] op0 = 3'b0, op1 = 3'b0;
  logic [3:0] a0 = 4'b0, a1 = 4'b0;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [7:0] result, acc;
  int         n_chk = 0;
  int         n_err = 0;
  int         n_done = 0;
  logic [8:0] q[$];
  logic [7:0] m_acc = 8'h00;
  alu_arbiter dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .op0(op0), .a0(a0),
    .req1(req1), .op1(op1), .a1(a1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .acc(acc), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] a, input logic [7:0] ac);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(ac[3:0]);
    case (op)
      3'd0, 3'd1: r = ia + ib;
      3'd2: r = (ia | ib) * 16 + (ia ^ ib);
      3'd3: r = ((ia | ib) != 0) ? 'h18 : 0;
      3'd4: r = ((ia & ib) == 15) ? 'hE7 : 0;
      3'd5: r = (ib >= 8) ? 0 : ((ia << ib) & 255);
      3'd6: r = ia * ib;
      default: r = int'(ac);
    endcase
    return r[7:0];
  endfunction
  always @(negedge clk) begin
    if (busy) chk("gnt_onehot", {31'b0, gnt0 & gnt1}, 0);
    if (done0 || done1) begin
      logic [8:0] e;
      n_done++;
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("done_side", {31'b0, done1}, {31'b0, e[8]});
        chk("result", {24'b0, result}, {24'b0, e[7:0]});
        chk("acc", {24'b0, acc}, {24'b0, e[7:0]});
        chk("done_gnt", {31'b0, done1 ? gnt1 : gnt0}, 1);
      end
    end
  end
  task automatic run_op(input logic s, input logic [2:0] op, input logic [3:0] a);
    int cyc, start;
    logic [7:0] e;
    e = model(op, a, m_acc);
    m_acc = e;
    q.push_back({s, e});
    if (s) begin req1 = 1'b1; op1 = op; a1 = a; end
    else begin req0 = 1'b1; op0 = op; a0 = a; end
    start = n_done;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk); #1;
      if (cyc == 1) chk("gnt_at_exec", {31'b0, s ? gnt1 : gnt0}, 1);
      if (n_done != start) break;
    end
    chk("latency", cyc, 2);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk); #1;
  endtask
  initial begin
    int start, cyc;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_acc", {24'b0, acc}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_gnt", {30'b0, gnt1, gnt0}, 0);
    chk("rst_done", {30'b0, done1, done0}, 0);
    resetn = 1'b1;
    @(negedge clk); #1;
    run_op(1'b0, 3'b001, 4'h5);
    run_op(1'b1, 3'b110, 4'h3);
    run_op(1'b0, 3'b000, 4'h1);
    run_op(1'b1, 3'b001, 4'hF);
    run_op(1'b0, 3'b100, 4'hF);
    run_op(1'b1, 3'b100, 4'h0);
    run_op(1'b0, 3'b011, 4'h0);
    run_op(1'b0, 3'b001, 4'h9);
    run_op(1'b1, 3'b101, 4'h1);
    run_op(1'b0, 3'b001, 4'hC);
    run_op(1'b1, 3'b110, 4'h5);
    run_op(1'b0, 3'b010, 4'hA);
    run_op(1'b1, 3'b111, 4'h6);
    run_op(1'b0, 3'b000, 4'hF);
    for (int i = 0; i < 12; i++)
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    req0 = 1'b1; op0 = 3'b001; a0 = 4'h3;
    @(negedge clk); #1;
    chk("busy_exec", {31'b0, busy}, 1);
    resetn = 1'b0;
    @(negedge clk); #1;
    chk("abort_acc", {24'b0, acc}, 0);
    chk("abort_gnt", {30'b0, gnt1, gnt0}, 0);
    chk("abort_done", {30'b0, done1, done0}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    resetn = 1'b1;
    req0 = 1'b0;
    m_acc = 8'h00;
    @(negedge clk); #1;
    q.push_back({1'b0, 8'h01});
    q.push_back({1'b1, 8'h03});
    q.push_back({1'b0, 8'h04});
    q.push_back({1'b1, 8'h06});
    op0 = 3'b001; a0 = 4'h1; op1 = 3'b001; a1 = 4'h2;
    req0 = 1'b1; req1 = 1'b1;
    start = n_done;
    for (cyc = 0; cyc < 40 && n_done - start < 4; cyc++) begin
      @(negedge clk); #1;
    end
    chk("alt_done_count", n_done - start, 4);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_after_alt", {31'b0, busy}, 0);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
